// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch front end; owns the PC, drives the ROM address
//            and registers the fetched word into IF/ID. Misaligned or
//            out-of-window PCs drop the stage into a sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] ROM_BASE  = 32'h0000_1000,
    parameter logic [31:0] ROM_TOP   = 32'h0000_1FFF,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [31:0] c_LAST_PC = ROM_TOP - 32'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [32:0] w_pc_plus4;
    logic        w_seq_legal;
    logic        w_target_legal;

    function automatic logic is_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= ROM_BASE) && (addr <= c_LAST_PC);
    endfunction

    // A carry out of the 32-bit increment is treated as an illegal address.
    assign w_pc_plus4     = {1'b0, pc_q} + 33'd4;
    assign w_seq_legal    = !w_pc_plus4[32] && is_legal(w_pc_plus4[31:0]);
    assign w_target_legal = is_legal(redirect_target);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_valid_d    = id_valid_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    id_instr_d = NOP_INSTR;
                    id_pc_d    = 32'd0;
                    id_valid_d = 1'b0;
                    if (w_target_legal) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_pc_d = redirect_target;
                    end
                end else if (!stall) begin
                    id_instr_d    = rom_dout;
                    id_pc_d       = pc_q;
                    id_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (w_seq_legal) begin
                        pc_d = w_pc_plus4[31:0];
                    end else begin
                        state_d    = ST_FAULT;
                        fault_pc_d = w_pc_plus4[31:0];
                    end
                end
            end
            ST_FAULT: begin
                // Drain IF/ID; PC, fault address and count stay frozen until reset.
                id_instr_d = NOP_INSTR;
                id_pc_d    = 32'd0;
                id_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'd0;
            id_valid_q    <= 1'b0;
            fault_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rom_addr    = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign fetch_fault = (state_q == ST_FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage; the ROM returns
//            32'hA000_0000 | address so every fetched word is predictable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .rom_addr        (rom_addr),
        .rom_dout        (rom_dout),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    assign rom_dout = 32'hA000_0000 | rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic valid);
        chk({tag, ".instr"}, id_instr, instr);
        chk({tag, ".pc"},    id_pc,    pc);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, valid});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rom_addr"}, rom_addr, 32'h0000_1000);
        chk_id(tag, c_NOP, 32'd0, 1'b0);
        chk({tag, ".fault"},    {31'd0, fetch_fault}, 32'd0);
        chk({tag, ".fault_pc"}, fault_pc, 32'd0);
        chk({tag, ".count"},    fetch_count, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
        tick();
        chk_reset("reset");

        // Free run through 0x1000 and 0x1004
        rst = 1'b0;
        tick();
        chk_id("run0", 32'hA000_1000, 32'h0000_1000, 1'b1);
        chk("run0.rom_addr", rom_addr, 32'h0000_1004);
        chk("run0.count", fetch_count, 32'd1);
        tick();
        chk_id("run1", 32'hA000_1004, 32'h0000_1004, 1'b1);
        chk("run1.rom_addr", rom_addr, 32'h0000_1008);

        // Stall three cycles with pc = 0x1008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.rom_addr", rom_addr, 32'h0000_1008);
            chk_id("stall", 32'hA000_1004, 32'h0000_1004, 1'b1);
            chk("stall.count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk_id("release", 32'hA000_1008, 32'h0000_1008, 1'b1);
        chk("release.count", fetch_count, 32'd3);
        tick();
        chk_id("run3", 32'hA000_100C, 32'h0000_100C, 1'b1);
        chk("run3.count", fetch_count, 32'd4);
        chk("run3.rom_addr", rom_addr, 32'h0000_1010);

        // Redirect beats stall
        redirect = 1'b1; redirect_target = 32'h0000_1040; stall = 1'b1;
        tick();
        chk("redir.rom_addr", rom_addr, 32'h0000_1040);
        chk_id("redir", c_NOP, 32'd0, 1'b0);
        chk("redir.count", fetch_count, 32'd4);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk_id("post_redir", 32'hA000_1040, 32'h0000_1040, 1'b1);
        chk("post_redir.count", fetch_count, 32'd5);

        // Misaligned redirect target faults; pc stays at 0x1044
        redirect = 1'b1; redirect_target = 32'h0000_1042;
        tick();
        chk("misal.fault", {31'd0, fetch_fault}, 32'd1);
        chk("misal.fault_pc", fault_pc, 32'h0000_1042);
        chk("misal.rom_addr", rom_addr, 32'h0000_1044);
        chk("misal.valid", {31'd0, id_valid}, 32'd0);
        redirect_target = 32'h0000_1000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fault_hold.fault", {31'd0, fetch_fault}, 32'd1);
            chk("fault_hold.rom_addr", rom_addr, 32'h0000_1044);
            chk("fault_hold.fault_pc", fault_pc, 32'h0000_1042);
            chk("fault_hold.count", fetch_count, 32'd5);
        end
        redirect = 1'b0;

        // Reset out of fault
        rst = 1'b1;
        tick();
        chk_reset("reset2");
        rst = 1'b0;

        // Walk off the top of the ROM window
        redirect = 1'b1; redirect_target = 32'h0000_1FF8;
        tick();
        chk("top.rom_addr", rom_addr, 32'h0000_1FF8);
        redirect = 1'b0;
        tick();
        chk_id("top0", 32'hA000_1FF8, 32'h0000_1FF8, 1'b1);
        chk("top0.rom_addr", rom_addr, 32'h0000_1FFC);
        chk("top0.fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        chk_id("top1", 32'hA000_1FFC, 32'h0000_1FFC, 1'b1);
        chk("top1.fault", {31'd0, fetch_fault}, 32'd1);
        chk("top1.fault_pc", fault_pc, 32'h0000_2000);
        chk("top1.rom_addr", rom_addr, 32'h0000_1FFC);
        chk("top1.count", fetch_count, 32'd2);
        tick();
        chk_id("top2", c_NOP, 32'd0, 1'b0);
        chk("top2.count", fetch_count, 32'd2);
        chk("top2.rom_addr", rom_addr, 32'h0000_1FFC);

        // Reset while faulted, with redirect also high, then resume
        rst = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_1100;
        tick();
        chk_reset("reset3");
        rst = 1'b0; redirect = 1'b0;
        tick();
        chk_id("resume", 32'hA000_1000, 32'h0000_1000, 1'b1);
        chk("resume.rom_addr", rom_addr, 32'h0000_1004);
        chk("resume.count", fetch_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the RISC-V core. Owns the program counter and drives the address input of the byte-addressed instruction ROM (ROM window 0x1000–0x1FFF).
- Captures the combinational 32-bit ROM word into an IF/ID pipeline register for the decoder.
- Supports stall, redirect (branch/jump) with flush, and a sticky fetch-fault state for misaligned or out-of-window PCs.

Parameters:
- RESET_PC, 32'h0000_1000, PC value loaded on reset.
- ROM_BASE, 32'h0000_1000, lowest legal fetch address.
- ROM_TOP, 32'h0000_1FFF, highest legal byte address; the last legal PC is ROM_TOP-3.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID when empty (addi x0,x0,0).

Ports:
- clk input 1: system clock; all state updates on the rising edge.
- rst input 1: synchronous, active-high reset.
- stall input 1: hold the PC and IF/ID contents.
- redirect input 1: take redirect_target next cycle and flush IF/ID.
- redirect_target input 32: new PC, computed by the execute/branch logic.
- rom_addr output 32: address to the instruction ROM; equals the pc register.
- rom_dout input 32: instruction word from the ROM, valid in the same cycle as rom_addr.
- id_instr output 32: registered instruction for decode.
- id_pc output 32: PC of id_instr.
- id_valid output 1: id_instr is a real fetched instruction.
- fetch_fault output 1: sticky fault flag.
- fault_pc output 32: offending PC captured on fault entry.
- fetch_count output 32: number of instructions loaded into IF/ID with id_valid=1.

Behaviour:
- Reset (rst=1 at an edge, overrides every other input):
  - pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_valid=0.
  - fetch_fault=0, fault_pc=0, fetch_count=0, state=RUN.
- rom_addr=pc, combinationally, in every state.
- States: RUN and FAULT.
- RUN, priority order per edge:
  1. redirect=1:
     - If redirect_target is legal: pc<=redirect_target; IF/ID<=NOP_INSTR/id_pc 0/id_valid 0. The current rom_dout is discarded.
     - If illegal: enter FAULT, fault_pc<=redirect_target.
     - Redirect wins over stall.
  2. stall=1: pc, id_instr, id_pc, id_valid and fetch_count all hold.
  3. Otherwise:
     - id_instr<=rom_dout, id_pc<=pc, id_valid<=1, fetch_count<=fetch_count+1.
     - pc<=pc+4 if pc+4 is legal.
     - If pc+4 is illegal: IF/ID still loads the current instruction, then next state is FAULT with fault_pc<=pc+4.
- Legality: addr[1:0]==2'b00 AND ROM_BASE ≤ addr ≤ ROM_TOP-3. Comparisons are unsigned 32-bit.
- FAULT:
  - fetch_fault=1 (registered, asserted from the cycle after the faulting edge).
  - pc frozen at its last legal value; IF/ID<=NOP_INSTR with id_valid=0 at the first FAULT edge, then held.
  - fetch_count frozen.
  - stall and redirect are ignored. Only rst exits FAULT.
- Latency: the instruction at address A appears on id_instr with id_valid=1 one cycle after pc==A, provided there is no stall or redirect.
- Width rules:
  - pc+4 is computed in 33 bits; a carry-out counts as illegal.
  - fetch_count wraps modulo 2^32 with no flag.
- Reset mid-stall or mid-fault returns to the reset values on that edge.

Test Plan:
- Reset then free-run with the ROM holding words W0..W3 at 0x1000..0x100C → rom_addr 0x1000,0x1004,…; id_instr=W0 with id_pc=0x1000 and id_valid=1 one cycle after reset deasserts; fetch_count=4 after 4 fetch edges.
- Stall for 3 cycles while pc=0x1008 → rom_addr stays 0x1008, id_instr/id_pc/fetch_count unchanged; the next edge after release loads the instruction at 0x1008.
- redirect=1 with target 0x1040 and stall=1 in the same cycle → pc=0x1040, id_valid=0, id_instr=0x00000013; the next edge loads the word at 0x1040 with id_valid=1.
- redirect to 0x1042 (misaligned) → fetch_fault=1, fault_pc=0x1042, pc unchanged, id_valid=0; later redirects to 0x1000 are ignored until rst.
- Sequential run reaching pc=0x1FFC → the word at 0x1FFC is loaded with id_valid=1, then fetch_fault=1 with fault_pc=0x2000; the following cycle id_valid=0.
- Assert rst while in FAULT → all outputs return to reset values and fetching resumes at 0x1000.
